pll_reset_sequencer: RTL and testbench

//  Consumer end of the PLL lock interface: watches the PLL LOCK output and sequences the SoC resets.

---
 rtl/pll_reset_sequencer.sv | 124 ++++++++++++
 tb/tb_pll_reset_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Watches PLL lock and sequences system/peripheral reset release; retries the PLL on lock timeout.
module pll_reset_sequencer #(
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned PERIPH_DELAY   = 256,
  parameter int unsigned LOCK_TIMEOUT   = 1048576,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned STAT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  output logic              pll_rst,
  output logic              sys_reset_n,
  output logic              periph_reset_n,
  output logic              ready,
  output logic [STAT_W-1:0] loss_count,
  output logic [STAT_W-1:0] retry_count
);

  localparam int unsigned MAX_A = (STABLE_CYCLES > PERIPH_DELAY) ? STABLE_CYCLES : PERIPH_DELAY;
  localparam int unsigned MAX_B = (LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES;
  localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W = $clog2(MAX_P);

  localparam logic [CNT_W-1:0]  STABLE_END = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  PERIPH_END = CNT_W'(PERIPH_DELAY - 1);
  localparam logic [CNT_W-1:0]  LOCK_END   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  PLLRST_END = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [STAT_W-1:0] STAT_MAX   = '1;

  typedef enum logic [2:0] {
    S_WAIT,
    S_STABLE,
    S_SYS,
    S_RUN,
    S_LOST,
    S_PLLRST
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              sync1_q, locked_s;
  logic              pll_rst_d, sys_reset_n_d, periph_reset_n_d, ready_d;
  logic [STAT_W-1:0] loss_d, retry_d;

  // Two-flop synchroniser for the asynchronous PLL lock signal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1_q  <= pll_locked;
      locked_s <= sync1_q;
    end
  end

  // Next state, next outputs and saturating statistics.
  always_comb begin
    state_d = state_q;
    loss_d  = loss_count;
    retry_d = retry_count;
    case (state_q)
      S_WAIT: begin
        if (locked_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == LOCK_END) begin
          state_d = S_PLLRST;
          if (retry_count != STAT_MAX) retry_d = retry_count + STAT_W'(1);
        end
      end
      S_STABLE: begin
        if (!locked_s) state_d = S_WAIT;
        else if (cnt_q == STABLE_END) state_d = S_SYS;
      end
      S_SYS: begin
        if (!locked_s) state_d = S_LOST;
        else if (cnt_q == PERIPH_END) state_d = S_RUN;
      end
      S_RUN: begin
        if (!locked_s) state_d = S_LOST;
      end
      S_LOST: begin
        state_d = S_WAIT;
      end
      S_PLLRST: begin
        if (cnt_q == PLLRST_END) state_d = S_WAIT;
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
    if (state_d == S_LOST && state_q != S_LOST && loss_count != STAT_MAX) begin
      loss_d = loss_count + STAT_W'(1);
    end
    pll_rst_d        = (state_d == S_PLLRST);
    sys_reset_n_d    = (state_d == S_SYS) || (state_d == S_RUN);
    periph_reset_n_d = (state_d == S_RUN);
    ready_d          = (state_d == S_RUN);
  end

  // State, shared cycle counter and registered outputs, all on the transition edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_WAIT;
      cnt_q          <= '0;
      pll_rst        <= 1'b0;
      sys_reset_n    <= 1'b0;
      periph_reset_n <= 1'b0;
      ready          <= 1'b0;
      loss_count     <= '0;
      retry_count    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
      pll_rst        <= pll_rst_d;
      sys_reset_n    <= sys_reset_n_d;
      periph_reset_n <= periph_reset_n_d;
      ready          <= ready_d;
      loss_count     <= loss_d;
      retry_count    <= retry_d;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with small timing parameters.
module tb_pll_reset_sequencer;

  localparam int unsigned SC = 4;
  localparam int unsigned PD = 3;
  localparam int unsigned LT = 20;
  localparam int unsigned PR = 5;
  localparam int unsigned SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic          pll_rst, sys_reset_n, periph_reset_n, ready;
  logic [SW-1:0] loss_count, retry_count;

  int passed = 0;
  int total  = 0;

  pll_reset_sequencer #(
    .STABLE_CYCLES (SC),
    .PERIPH_DELAY  (PD),
    .LOCK_TIMEOUT  (LT),
    .PLL_RST_CYCLES(PR),
    .STAT_W        (SW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .sys_reset_n   (sys_reset_n),
    .periph_reset_n(periph_reset_n),
    .ready         (ready),
    .loss_count    (loss_count),
    .retry_count   (retry_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Reference model: phase plus how long it has lasted, driven by the two-sample-delayed lock.
  localparam int PH_WAIT = 0, PH_STABLE = 1, PH_SYS = 2, PH_RUN = 3, PH_LOST = 4, PH_PLLRST = 5;
  int ph = PH_WAIT;
  int t  = 0;
  int m_loss = 0, m_retry = 0;
  bit m_s1 = 1'b0, m_s2 = 1'b0;
  localparam int STAT_MAX = (1 << SW) - 1;

  initial begin
    bit lk;
    int lasted;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        ph = PH_WAIT; t = 0; m_loss = 0; m_retry = 0; m_s1 = 1'b0; m_s2 = 1'b0;
      end else begin
        lk = m_s2; m_s2 = m_s1; m_s1 = pll_locked;
        lasted = t + 1;
        t = lasted;
        case (ph)
          PH_WAIT:
            if (lk) begin ph = PH_STABLE; t = 0; end
            else if (lasted == LT) begin
              ph = PH_PLLRST; t = 0;
              if (m_retry < STAT_MAX) m_retry++;
            end
          PH_STABLE:
            if (!lk) begin ph = PH_WAIT; t = 0; end
            else if (lasted == SC) begin ph = PH_SYS; t = 0; end
          PH_SYS, PH_RUN:
            if (!lk) begin
              ph = PH_LOST; t = 0;
              if (m_loss < STAT_MAX) m_loss++;
            end else if (ph == PH_SYS && lasted == PD) begin ph = PH_RUN; t = 0; end
          PH_LOST: begin ph = PH_WAIT; t = 0; end
          default: if (lasted == PR) begin ph = PH_WAIT; t = 0; end
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("m_sys_reset_n", int'(sys_reset_n), int'(ph == PH_SYS || ph == PH_RUN));
        check("m_periph_reset_n", int'(periph_reset_n), int'(ph == PH_RUN));
        check("m_ready", int'(ready), int'(ph == PH_RUN));
        check("m_pll_rst", int'(pll_rst), int'(ph == PH_PLLRST));
        check("m_loss_count", int'(loss_count), m_loss);
        check("m_retry_count", int'(retry_count), m_retry);
      end
    end
  end

  // Assert lock now (just after an edge) and pin the release latency.
  task automatic lock_and_check(input string tag);
    pll_locked = 1'b1;
    repeat (6) @(posedge clk);
    #1 check({tag, "_sys_pre"}, int'(sys_reset_n), 0);
    @(posedge clk);
    #1 check({tag, "_sys_rise"}, int'(sys_reset_n), 1);
    repeat (2) @(posedge clk);
    #1 check({tag, "_periph_pre"}, int'(periph_reset_n), 0);
    @(posedge clk);
    #1 check({tag, "_periph_rise"}, int'(periph_reset_n), 1);
    check({tag, "_ready_rise"}, int'(ready), 1);
    check({tag, "_pll_rst"}, int'(pll_rst), 0);
  endtask

  initial begin
    #3;
    check("rst_sys", int'(sys_reset_n), 0);
    check("rst_periph", int'(periph_reset_n), 0);
    check("rst_pll", int'(pll_rst), 0);
    check("rst_retry", int'(retry_count), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Lock, glitch low for 3 samples while stable, then relock.
    @(posedge clk);
    #1 pll_locked = 1'b1;
    repeat (3) @(posedge clk);
    #1 pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("glitch_sys", int'(sys_reset_n), 0);
    lock_and_check("relock");

    // Lock loss in RUN.
    pll_locked = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("drop_sys_e1", int'(sys_reset_n), 1);
    @(posedge clk);
    #1 check("drop_sys_e2", int'(sys_reset_n), 0);
    check("drop_periph_e2", int'(periph_reset_n), 0);
    check("drop_ready_e2", int'(ready), 0);
    check("drop_loss", int'(loss_count), 1);
    repeat (4) @(posedge clk);
    #1 lock_and_check("after_loss");

    // Leave RUN again, then drop lock exactly when SYS times out.
    pll_locked = 1'b0;
    repeat (5) @(posedge clk);
    #1 pll_locked = 1'b1;
    repeat (7) @(posedge clk);
    #1 pll_locked = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("edge_sys_in_sys", int'(sys_reset_n), 1);
    @(posedge clk);
    #1 check("edge_periph", int'(periph_reset_n), 0);
    check("edge_sys_lost", int'(sys_reset_n), 0);
    check("edge_loss", int'(loss_count), 3);
    repeat (4) @(posedge clk);
    #1 check("edge_periph_never", int'(periph_reset_n), 0);
    lock_and_check("third");

    // Saturated loss count holds.
    pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("loss_sat", int'(loss_count), 3);
    repeat (2) @(posedge clk);
    #1 lock_and_check("fourth");

    // Asynchronous reset between edges in RUN.
    #3 rst_n = 1'b0;
    #1 check("arst_sys", int'(sys_reset_n), 0);
    check("arst_periph", int'(periph_reset_n), 0);
    check("arst_ready", int'(ready), 0);
    check("arst_loss", int'(loss_count), 0);
    check("arst_retry", int'(retry_count), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("restart_sys_pre", int'(sys_reset_n), 0);
    @(posedge clk);
    #1 check("restart_sys_rise", int'(sys_reset_n), 1);

    // Lock timeout and PLL reset pulses.
    rst_n = 1'b0;
    pll_locked = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (19) @(posedge clk);
    #1 check("to_pll_pre", int'(pll_rst), 0);
    @(posedge clk);
    #1 check("to_pll_rise", int'(pll_rst), 1);
    check("to_retry1", int'(retry_count), 1);
    repeat (4) @(posedge clk);
    #1 check("to_pll_last", int'(pll_rst), 1);
    @(posedge clk);
    #1 check("to_pll_fall", int'(pll_rst), 0);
    repeat (20) @(posedge clk);
    #1 check("to_retry2", int'(retry_count), 2);
    repeat (55) @(posedge clk);
    #1 check("to_retry_sat", int'(retry_count), 3);
    check("to_sys_held", int'(sys_reset_n), 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
